rename_regfile: RTL

RENAME_REGFILE -- requirements
Module: rename_regfile

---
 rtl/rename_regfile_pkg.sv | 19 +
 rtl/rename_regfile_if.sv | 49 ++++
 rtl/rename_regfile_read_port.sv | 43 ++++
 rtl/rename_regfile.sv | 109 ++++++++++
 4 files changed

// File: rtl/rename_regfile_pkg.sv
// Shared data structures for the rename register file: default widths and
// the per-register entry layout {value, valid, tag}.
package rename_regfile_pkg;

    localparam int DEFAULT_NUM_REGS = 32;
    localparam int DEFAULT_DATA_W   = 64;
    localparam int DEFAULT_TAG_W    = 4;
    localparam int DEFAULT_NUM_RD   = 2;
    localparam int DEFAULT_ZERO_REG = 31;

    // One architectural register: committed value, ready flag and the ROB tag
    // of the youngest outstanding producer (meaningful only when valid=0).
    typedef struct packed {
        logic [DEFAULT_DATA_W-1:0] value;
        logic                      valid;
        logic [DEFAULT_TAG_W-1:0]  tag;
    } gpr_entry_t;

endpackage

// File: rtl/rename_regfile_if.sv
// Commit, dispatch-rename, flush and source-read signals of the rename
// register file. The master side is the ROB/dispatch logic, the slave side is
// the register file itself.
interface rename_regfile_if
    import rename_regfile_pkg::*;
#(
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int TAG_W    = DEFAULT_TAG_W,
    parameter int NUM_RD   = DEFAULT_NUM_RD
) ();

    localparam int IDX_W = $clog2(NUM_REGS);

    // ROB commit
    logic                           in_rob_should_commit;
    logic [IDX_W-1:0]               in_rob_regfile_index;
    logic [DATA_W-1:0]              in_rob_commit_value;
    logic [TAG_W-1:0]               in_rob_commit_tag;

    // Dispatch rename and source lookup
    logic                           in_d_should_rename;
    logic [IDX_W-1:0]               in_d_dst;
    logic [TAG_W-1:0]               in_d_dst_tag;
    logic [NUM_RD-1:0][IDX_W-1:0]   in_d_op;

    // Mispredict recovery
    logic                           in_flush;

    // Source operand results
    logic [NUM_RD-1:0][DATA_W-1:0]  out_d_op_value;
    logic [NUM_RD-1:0]              out_d_op_valid;
    logic [NUM_RD-1:0][TAG_W-1:0]   out_d_op_tag;

    modport master (
        output in_rob_should_commit, in_rob_regfile_index, in_rob_commit_value,
               in_rob_commit_tag, in_d_should_rename, in_d_dst, in_d_dst_tag,
               in_d_op, in_flush,
        input  out_d_op_value, out_d_op_valid, out_d_op_tag
    );

    modport slave (
        input  in_rob_should_commit, in_rob_regfile_index, in_rob_commit_value,
               in_rob_commit_tag, in_d_should_rename, in_d_dst, in_d_dst_tag,
               in_d_op, in_flush,
        output out_d_op_value, out_d_op_valid, out_d_op_tag
    );

endinterface

// File: rtl/rename_regfile_read_port.sv
// One dispatch source read: turns the selected register entry into the
// operand result, forcing the zero register and out-of-range indices to a
// ready zero and forwarding a same-cycle commit to a pending source.
module regfile_read_port
    import rename_regfile_pkg::*;
#(
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int TAG_W    = DEFAULT_TAG_W,
    parameter int ZERO_REG = DEFAULT_ZERO_REG,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic [IDX_W-1:0]  rd_idx,
    input  logic [DATA_W-1:0] ent_value,
    input  logic              ent_valid,
    input  logic [TAG_W-1:0]  ent_tag,
    input  logic              commit_en,
    input  logic [IDX_W-1:0]  commit_idx,
    input  logic [DATA_W-1:0] commit_value,
    input  logic [TAG_W-1:0]  commit_tag,
    output logic [DATA_W-1:0] out_value,
    output logic              out_valid,
    output logic [TAG_W-1:0]  out_tag
);

    // Zero-register/out-of-range override first, then commit bypass, else entry.
    always_comb begin
        out_value = ent_value;
        out_valid = ent_valid;
        out_tag   = ent_tag;
        if (int'(rd_idx) == ZERO_REG || int'(rd_idx) >= NUM_REGS) begin
            out_value = '0;
            out_valid = 1'b1;
            out_tag   = '0;
        end else if (commit_en && commit_idx == rd_idx && !ent_valid &&
                     commit_tag == ent_tag) begin
            // The producer we are waiting on is retiring right now.
            out_value = commit_value;
            out_valid = 1'b1;
        end
    end

endmodule

// File: rtl/rename_regfile.sv
// Architectural register file with rename state: each register holds its
// committed value plus a ready flag and the ROB tag of the pending producer.
// Reads are combinational with commit bypass; commits, renames and flushes
// update state on the rising clock edge.
module rename_regfile
    import rename_regfile_pkg::*;
#(
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int TAG_W    = DEFAULT_TAG_W,
    parameter int NUM_RD   = DEFAULT_NUM_RD,
    parameter int ZERO_REG = DEFAULT_ZERO_REG
) (
    input  logic             in_clk,
    input  logic             in_rst,
    rename_regfile_if.slave  bus
);

    localparam int IDX_W = $clog2(NUM_REGS);

    // Same layout as gpr_entry_t, sized by this instance's parameters.
    typedef struct packed {
        logic [DATA_W-1:0] value;
        logic              valid;
        logic [TAG_W-1:0]  tag;
    } entry_t;

    entry_t entries_q [NUM_REGS];
    entry_t entries_d [NUM_REGS];
    entry_t rd_ent    [NUM_RD];

    logic [NUM_RD-1:0][DATA_W-1:0] rd_value;
    logic [NUM_RD-1:0]             rd_valid;
    logic [NUM_RD-1:0][TAG_W-1:0]  rd_tag;

    // Next state: commit writes the value (ready only if the tag matches),
    // a rename then overrides ready/tag, and a flush marks everything ready.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            entries_d[i] = entries_q[i];
            if (i != ZERO_REG) begin
                if (bus.in_rob_should_commit && bus.in_rob_regfile_index == IDX_W'(i)) begin
                    entries_d[i].value = bus.in_rob_commit_value;
                    // A mismatched tag means a younger producer is still outstanding.
                    if (bus.in_rob_commit_tag == entries_q[i].tag) begin
                        entries_d[i].valid = 1'b1;
                    end
                end
                if (bus.in_d_should_rename && !bus.in_flush && bus.in_d_dst == IDX_W'(i)) begin
                    entries_d[i].valid = 1'b0;
                    entries_d[i].tag   = bus.in_d_dst_tag;
                end
            end
            if (bus.in_flush) begin
                entries_d[i].valid = 1'b1;
            end
        end
    end

    // Register state; reset overrides every same-cycle update.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                entries_q[i] <= '{value: '0, valid: 1'b1, tag: '0};
            end
        end else begin
            entries_q <= entries_d;
        end
    end

    // Select the pre-update entry for each source index (out-of-range gives zero).
    always_comb begin
        for (int r = 0; r < NUM_RD; r++) begin
            rd_ent[r] = '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (bus.in_d_op[r] == IDX_W'(i)) begin
                    rd_ent[r] = entries_q[i];
                end
            end
        end
    end

    for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
        regfile_read_port #(
            .NUM_REGS (NUM_REGS),
            .DATA_W   (DATA_W),
            .TAG_W    (TAG_W),
            .ZERO_REG (ZERO_REG),
            .IDX_W    (IDX_W)
        ) u_rd (
            .rd_idx       (bus.in_d_op[r]),
            .ent_value    (rd_ent[r].value),
            .ent_valid    (rd_ent[r].valid),
            .ent_tag      (rd_ent[r].tag),
            .commit_en    (bus.in_rob_should_commit),
            .commit_idx   (bus.in_rob_regfile_index),
            .commit_value (bus.in_rob_commit_value),
            .commit_tag   (bus.in_rob_commit_tag),
            .out_value    (rd_value[r]),
            .out_valid    (rd_valid[r]),
            .out_tag      (rd_tag[r])
        );
    end

    assign bus.out_d_op_value = rd_value;
    assign bus.out_d_op_valid = rd_valid;
    assign bus.out_d_op_tag   = rd_tag;

endmodule
